// File: rtl/alu_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_ctrl
// Purpose  : Issue controller / round-robin arbiter for the shared iterative
//            multiply/divide engine. Converts signed operands to magnitudes,
//            handles divide special cases without the engine, applies sign
//            fix-up and returns a tagged 2*OPR_LEN-bit result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_md_ctrl #(
  parameter int OPR_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [3:0]             req0_op,
  input  logic [OPR_LEN-1:0]     req0_a,
  input  logic [OPR_LEN-1:0]     req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [3:0]             req1_op,
  input  logic [OPR_LEN-1:0]     req1_a,
  input  logic [OPR_LEN-1:0]     req1_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [2*OPR_LEN-1:0]   resp_data,
  output logic                   resp_err,
  output logic                   eng_start,
  output logic                   eng_div,
  output logic [OPR_LEN-1:0]     eng_a,
  output logic [OPR_LEN-1:0]     eng_b,
  input  logic                   eng_done,
  input  logic [2*OPR_LEN-1:0]   eng_prod,
  input  logic [OPR_LEN-1:0]     eng_quot,
  input  logic [OPR_LEN-1:0]     eng_rem
);

  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULU  = 4'b1001;
  localparam logic [3:0] OP_MULSU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REM   = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;
  localparam int         MSB      = OPR_LEN - 1;
  localparam logic [OPR_LEN-1:0] MIN_NEG  = {1'b1, {(OPR_LEN-1){1'b0}}};
  localparam logic [OPR_LEN-1:0] ALL_ONES = '1;
  localparam logic [OPR_LEN-1:0] ZERO_W   = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                 state;
  logic                   last_grant;
  logic                   grant;
  logic                   accept;

  logic [3:0]             sel_op;
  logic [OPR_LEN-1:0]     sel_a;
  logic [OPR_LEN-1:0]     sel_b;
  logic                   sel_illegal;
  logic                   sel_is_div;
  logic                   sel_special;
  logic                   sel_neg;
  logic [OPR_LEN-1:0]     mag_a;
  logic [OPR_LEN-1:0]     mag_b;

  logic [3:0]             op_q;
  logic [OPR_LEN-1:0]     a_q;
  logic [OPR_LEN-1:0]     b_q;
  logic                   id_q;
  logic                   neg_q;
  logic                   special_q;
  logic [2*OPR_LEN-1:0]   prod_q;
  logic [OPR_LEN-1:0]     quot_q;
  logic [OPR_LEN-1:0]     rem_q;

  logic [2*OPR_LEN-1:0]   special_data;
  logic                   special_err;
  logic [2*OPR_LEN-1:0]   fix_data;

  // Round-robin grant: the sole valid requester, or on a tie the one not granted last
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = rst && (state == S_IDLE) && req0_valid && !grant;
  assign req1_ready = rst && (state == S_IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  assign sel_illegal = (sel_op[3] == 1'b0) || (sel_op == 4'b1111);
  assign sel_is_div  = sel_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  // Divide-by-zero and signed overflow never reach the engine
  assign sel_special = sel_illegal
                     || (sel_is_div && (sel_b == ZERO_W))
                     || ((sel_op == OP_DIV || sel_op == OP_REM)
                         && (sel_a == MIN_NEG) && (sel_b == ALL_ONES));

  // Operand magnitudes and result-sign flag for the granted request
  always_comb begin
    mag_a   = sel_a;
    mag_b   = sel_b;
    sel_neg = 1'b0;
    case (sel_op)
      OP_MUL, OP_DIV: begin
        if (sel_a[MSB]) mag_a = -sel_a;
        if (sel_b[MSB]) mag_b = -sel_b;
        sel_neg = sel_a[MSB] ^ sel_b[MSB];
      end
      OP_MULSU: begin
        if (sel_a[MSB]) mag_a = -sel_a;
        sel_neg = sel_a[MSB];
      end
      OP_REM: begin
        // Remainder takes the dividend's sign; divisor magnitude still used
        if (sel_a[MSB]) mag_a = -sel_a;
        if (sel_b[MSB]) mag_b = -sel_b;
        sel_neg = sel_a[MSB];
      end
      default: ;
    endcase
  end

  // Bypass result for illegal ops, divide by zero and signed overflow
  always_comb begin
    special_data = '0;
    special_err  = 1'b0;
    if ((op_q[3] == 1'b0) || (op_q == 4'b1111)) begin
      special_err = 1'b1;
    end else if (b_q == ZERO_W) begin
      if (op_q == OP_DIV || op_q == OP_DIVU) special_data = {ZERO_W, ALL_ONES};
      else                                   special_data = {ZERO_W, a_q};
    end else if (op_q == OP_DIV) begin
      special_data = {ZERO_W, MIN_NEG};
    end
  end

  // Sign fix-up of the captured engine result
  always_comb begin
    case (op_q)
      OP_MUL, OP_MULU, OP_MULSU: fix_data = neg_q ? -prod_q : prod_q;
      OP_DIV, OP_DIVU:           fix_data = {ZERO_W, (neg_q ? -quot_q : quot_q)};
      default:                   fix_data = {ZERO_W, (neg_q ? -rem_q : rem_q)};
    endcase
  end

  // Control FSM with registered engine and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      eng_start  <= 1'b0;
      eng_div    <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      prod_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant;
            neg_q      <= sel_neg;
            special_q  <= sel_special;
            last_grant <= grant;
            // Start pulse is raised here so it is visible in the ISSUE cycle
            eng_start  <= !sel_special;
            eng_div    <= sel_is_div;
            eng_a      <= mag_a;
            eng_b      <= mag_b;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_start <= 1'b0;
          if (special_q) begin
            resp_data  <= special_data;
            resp_err   <= special_err;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            prod_q <= eng_prod;
            quot_q <= eng_quot;
            rem_q  <= eng_rem;
            state  <= S_FIX;
          end
        end
        S_FIX: begin
          resp_data  <= fix_data;
          resp_err   <= 1'b0;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md_ctrl
// Purpose  : Directed self-checking bench for alu_md_ctrl with a scripted
//            engine responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_md_ctrl;

  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [63:0] resp_data;
  logic        eng_start, eng_div, eng_done;
  logic [31:0] eng_a, eng_b, eng_quot, eng_rem;
  logic [63:0] eng_prod;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int t_acc, t_start, t_done, t_resp;
  logic [31:0] cap_a, cap_b;
  logic        cap_div;

  alu_md_ctrl #(.OPR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .eng_start(eng_start), .eng_div(eng_div), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_prod(eng_prod), .eng_quot(eng_quot), .eng_rem(eng_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eng_start === 1'b1) start_cnt <= start_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; eng_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    t_acc = -1;
    @(posedge clk); #1;
    if (!id) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else     begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin t_acc = cyc; break; end
    end
    compared++;
    if (t_acc < 0) begin
      failed++;
      $display("FAIL send_timeout: req%0d_ready stayed 0, expected 1", id);
    end
    @(posedge clk); #1;
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic run_engine(input logic [63:0] prod, input logic [31:0] quot, input logic [31:0] rem);
    t_start = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        t_start = cyc; cap_a = eng_a; cap_b = eng_b; cap_div = eng_div;
        break;
      end
    end
    compared++;
    if (t_start < 0) begin
      failed++;
      $display("FAIL eng_start_timeout: eng_start stayed 0, expected a pulse");
    end
    @(posedge clk); #1;
    eng_done = 1'b1; eng_prod = prod; eng_quot = quot; eng_rem = rem;
    @(negedge clk);
    t_done = cyc;
    compared++;
    if (eng_start !== 1'b0) begin
      failed++;
      $display("FAIL eng_start_width: eng_start=%b one cycle later, expected 0", eng_start);
    end
    @(posedge clk); #1;
    eng_done = 1'b0;
  endtask

  task automatic wait_resp();
    t_resp = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin t_resp = cyc; break; end
    end
    compared++;
    if (t_resp < 0) begin
      failed++;
      $display("FAIL resp_timeout: resp_valid stayed 0, expected 1");
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = OP_MUL; req1_op = OP_MUL; req0_a = 1; req0_b = 1; req1_a = 1; req1_b = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failed++; $display("FAIL reset_ready: got %b, expected 00", {req0_ready, req1_ready});
    end
    compared++;
    if ({resp_valid, resp_id, resp_err} !== 3'b000) begin
      failed++; $display("FAIL reset_resp_flags: got %b, expected 000", {resp_valid, resp_id, resp_err});
    end
    compared++;
    if (resp_data !== 64'd0) begin
      failed++; $display("FAIL reset_resp_data: got %h, expected 0", resp_data);
    end
    compared++;
    if ({eng_start, eng_div, eng_a, eng_b} !== 66'd0) begin
      failed++; $display("FAIL reset_eng: got start=%b div=%b a=%h b=%h, expected all 0",
                         eng_start, eng_div, eng_a, eng_b);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_mul();
    send(1'b0, OP_MUL, 32'hFFFF_FFFD, 32'd7);
    run_engine(64'd21, 32'd0, 32'd0);
    wait_resp();
    compared++;
    if (t_start !== t_acc + 1) begin
      failed++; $display("FAIL mul_start_latency: got %0d, expected %0d", t_start, t_acc + 1);
    end
    compared++;
    if ({cap_div, cap_a, cap_b} !== {1'b0, 32'd3, 32'd7}) begin
      failed++; $display("FAIL mul_eng_operands: got div=%b a=%h b=%h, expected div=0 a=3 b=7",
                         cap_div, cap_a, cap_b);
    end
    compared++;
    if (t_resp !== t_done + 2) begin
      failed++; $display("FAIL mul_resp_latency: got %0d, expected %0d", t_resp, t_done + 2);
    end
    compared++;
    if (resp_data !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failed++; $display("FAIL mul_data: got %h, expected ffffffffffffffeb", resp_data);
    end
    compared++;
    if ({resp_id, resp_err} !== 2'b00) begin
      failed++; $display("FAIL mul_id_err: got %b, expected 00", {resp_id, resp_err});
    end
  endtask

  task automatic test_back_to_back();
    logic r0, r1, exp_id;
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = OP_DIVU; req0_a = 32'd100; req0_b = 32'd7;
    req1_valid = 1'b1; req1_op = OP_DIVU; req1_a = 32'd100; req1_b = 32'd7;
    for (int k = 0; k < 3; k++) begin
      exp_id = (k == 1);
      r0 = 1'b0; r1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
          r0 = req0_ready; r1 = req1_ready; break;
        end
      end
      compared++;
      if ({r0, r1} !== {~exp_id, exp_id}) begin
        failed++; $display("FAIL arb_grant_%0d: got ready0/1=%b%b, expected %b%b", k, r0, r1, ~exp_id, exp_id);
      end
      @(posedge clk); #1;
      if (k == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      run_engine(64'd0, 32'd14, 32'd2);
      compared++;
      if ({cap_div, cap_a, cap_b} !== {1'b1, 32'd100, 32'd7}) begin
        failed++; $display("FAIL arb_eng_%0d: got div=%b a=%h b=%h, expected div=1 a=64 b=7",
                           k, cap_div, cap_a, cap_b);
      end
      wait_resp();
      compared++;
      if ({resp_id, resp_data} !== {exp_id, 64'd14}) begin
        failed++; $display("FAIL arb_resp_%0d: got id=%b data=%h, expected id=%b data=e",
                           k, resp_id, resp_data, exp_id);
      end
    end
  endtask

  task automatic test_special();
    int sc0, prev_resp;
    @(posedge clk); #1;
    sc0 = start_cnt;
    send(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_resp();
    compared++;
    if (t_resp !== t_acc + 2) begin
      failed++; $display("FAIL ovf_latency: got %0d, expected %0d", t_resp, t_acc + 2);
    end
    compared++;
    if ({resp_err, resp_data} !== {1'b0, 64'h0000_0000_8000_0000}) begin
      failed++; $display("FAIL ovf_div: got err=%b data=%h, expected err=0 data=80000000", resp_err, resp_data);
    end
    prev_resp = t_resp;
    send(1'b1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    compared++;
    if (t_acc !== prev_resp + 1) begin
      failed++; $display("FAIL min_spacing: accept at %0d, expected %0d", t_acc, prev_resp + 1);
    end
    wait_resp();
    compared++;
    if ({resp_id, resp_data} !== {1'b1, 64'd0}) begin
      failed++; $display("FAIL ovf_rem: got id=%b data=%h, expected id=1 data=0", resp_id, resp_data);
    end
    send(1'b0, OP_DIVU, 32'd5, 32'd0);
    wait_resp();
    compared++;
    if (resp_data !== 64'h0000_0000_FFFF_FFFF) begin
      failed++; $display("FAIL divu_by_zero: got %h, expected 00000000ffffffff", resp_data);
    end
    send(1'b1, OP_REM, 32'hFFFF_FFF9, 32'd0);
    wait_resp();
    compared++;
    if (resp_data !== 64'h0000_0000_FFFF_FFF9) begin
      failed++; $display("FAIL rem_by_zero: got %h, expected 00000000fffffff9", resp_data);
    end
    send(1'b0, 4'b0011, 32'd1, 32'd2);
    wait_resp();
    compared++;
    if ({resp_err, resp_data} !== {1'b1, 64'd0}) begin
      failed++; $display("FAIL illegal_op: got err=%b data=%h, expected err=1 data=0", resp_err, resp_data);
    end
    compared++;
    if (t_resp !== t_acc + 2) begin
      failed++; $display("FAIL illegal_latency: got %0d, expected %0d", t_resp, t_acc + 2);
    end
    @(posedge clk); #1;
    compared++;
    if (start_cnt !== sc0) begin
      failed++; $display("FAIL special_no_start: eng_start pulses %0d, expected 0", start_cnt - sc0);
    end
  endtask

  task automatic test_stall();
    resp_ready = 1'b0;
    send(1'b1, OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_engine(64'd0, 32'd3, 32'd1);
    compared++;
    if ({cap_div, cap_a, cap_b} !== {1'b1, 32'd7, 32'd2}) begin
      failed++; $display("FAIL rem_eng_operands: got div=%b a=%h b=%h, expected div=1 a=7 b=2",
                         cap_div, cap_a, cap_b);
    end
    wait_resp();
    compared++;
    if ({resp_id, resp_data} !== {1'b1, 64'h0000_0000_FFFF_FFFF}) begin
      failed++; $display("FAIL rem_neg: got id=%b data=%h, expected id=1 data=00000000ffffffff", resp_id, resp_data);
    end
    req0_valid = 1'b1; req0_op = OP_MULU; req0_a = 32'd1; req0_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({resp_valid, resp_data} !== {1'b1, 64'h0000_0000_FFFF_FFFF}) begin
        failed++; $display("FAIL stall_hold_%0d: got valid=%b data=%h, expected valid=1 data=00000000ffffffff",
                           i, resp_valid, resp_data);
      end
      compared++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        failed++; $display("FAIL stall_ready_%0d: got %b, expected 00", i, {req0_ready, req1_ready});
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    compared++;
    if ({resp_valid, req0_ready} !== 2'b01) begin
      failed++; $display("FAIL stall_release: got valid=%b ready0=%b, expected valid=0 ready0=1",
                         resp_valid, req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int hits;
    send(1'b0, OP_MULU, 32'd3, 32'd4);
    @(posedge clk); #1;
    rst = 1'b0; eng_done = 1'b1; eng_prod = 64'd99;
    @(posedge clk); #1;
    eng_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b1; eng_prod = 64'd77;
    @(posedge clk); #1;
    eng_done = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) hits++;
    end
    compared++;
    if (hits !== 0) begin
      failed++; $display("FAIL stale_done: resp_valid high for %0d cycles, expected 0", hits);
    end
    compared++;
    if ({eng_a, eng_b} !== 64'd0) begin
      failed++; $display("FAIL reset_eng_clear: got a=%h b=%h, expected 0", eng_a, eng_b);
    end
    send(1'b0, OP_MULU, 32'd3, 32'd4);
    run_engine(64'd12, 32'd0, 32'd0);
    wait_resp();
    compared++;
    if ({resp_data, t_resp} !== {64'd12, t_done + 2}) begin
      failed++; $display("FAIL post_reset_txn: got data=%h at %0d, expected data=c at %0d",
                         resp_data, t_resp, t_done + 2);
    end
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b1;
    eng_done = 1'b0; eng_prod = '0; eng_quot = '0; eng_rem = '0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_special();
    test_stall();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire
